// File: rtl/stream_fifo_pkg.sv
// Shared types and constants for the stream_fifo valid/ready buffer.
// Pointer width helper includes one extra wrap bit above the index bits.
package stream_fifo_pkg;

    localparam int SF_DEF_WIDTH = 8;
    localparam int SF_DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        SF_EMPTY   = 2'd0,
        SF_PARTIAL = 2'd1,
        SF_FULL    = 2'd2
    } sf_state_e;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// The array has no reset; contents are only meaningful behind the FIFO pointers.
module stream_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage write on accepted producer beat
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides and a registered almost-full flag.
// Optional macro STREAM_FIFO_LEVEL_EN adds a registered occupancy output o_level.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int WIDTH    = SF_DEF_WIDTH,
    parameter int DEPTH    = SF_DEF_DEPTH,
    parameter int AFULL_TH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        i_data,
    input  logic                    i_valid,
    output logic                    i_ready,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic                    o_afull
`ifdef STREAM_FIFO_LEVEL_EN
    ,
    output logic [ptr_w(DEPTH)-1:0] o_level
`endif
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_TH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (AFULL_TH < 1) || (AFULL_TH > DEPTH)) begin : g_bad_param
        $fatal(1, "stream_fifo: DEPTH must be a power of 2 >= 2 and 1 <= AFULL_TH <= DEPTH");
    end

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] occ_s;
    logic [PW-1:0] occ_nxt_s;
    logic          full_s;
    logic          empty_s;
    logic          wr_en_s;
    logic          rd_en_s;
    logic          afull_r;

    // Wrap bit disambiguates full from empty when the index bits match
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign i_ready = ~full_s & rst;
    assign o_valid = ~empty_s;
    assign wr_en_s = i_valid & i_ready;
    assign rd_en_s = o_valid & o_ready;
    assign occ_s   = wr_ptr_r - rd_ptr_r;
    assign o_afull = afull_r;

    // Occupancy after this edge, used for registered flags
    always_comb begin
        occ_nxt_s = occ_s;
        case ({wr_en_s, rd_en_s})
            2'b10:   occ_nxt_s = occ_s + PTR_ONE;
            2'b01:   occ_nxt_s = occ_s - PTR_ONE;
            default: occ_nxt_s = occ_s;
        endcase
    end

    // Pointer and almost-full state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            afull_r  <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            afull_r <= (occ_nxt_s >= AFULL_LVL);
        end
    end

`ifdef STREAM_FIFO_LEVEL_EN
    logic [PW-1:0] level_r;

    // Registered occupancy for the level port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_r <= {PW{1'b0}};
        end else begin
            level_r <= occ_nxt_s;
        end
    end

    assign o_level = level_r;
`endif

    stream_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en_s),
        .waddr (wr_ptr_r[AW-1:0]),
        .wdata (i_data),
        .raddr (rd_ptr_r[AW-1:0]),
        .rdata (o_data)
    );

endmodule

// File: tb/tb_stream_fifo.sv
// Directed self-checking bench for stream_fifo (WIDTH=8, DEPTH=4, AFULL_TH=3).
// Level checks are compiled in only when STREAM_FIFO_LEVEL_EN is defined.
module tb_stream_fifo;
    import stream_fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_data;
    logic       i_valid;
    logic       i_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_ready;
    logic       o_afull;
`ifdef STREAM_FIFO_LEVEL_EN
    logic [2:0] o_level;
`endif

    int vectors = 0;
    int miscompares = 0;

    stream_fifo #(.WIDTH(8), .DEPTH(4), .AFULL_TH(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_afull (o_afull)
`ifdef STREAM_FIFO_LEVEL_EN
        ,
        .o_level (o_level)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; i_valid = 1'b0; o_ready = 1'b0; i_data = 8'h00;
        repeat (3) cyc();
        vectors++;
        if ({o_valid, i_ready, o_afull} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_held: got v/r/af=%b want 000", {o_valid, i_ready, o_afull});
        end
        rst = 1'b1;
        cyc();
        vectors++;
        if ({o_valid, i_ready, o_afull} !== 3'b010) begin
            miscompares++;
            $display("FAIL reset_idle: got v/r/af=%b want 010", {o_valid, i_ready, o_afull});
        end
`ifdef STREAM_FIFO_LEVEL_EN
        vectors++;
        if (o_level !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_level: got %0d want 0", o_level);
        end
`endif
    endtask

    task automatic test_fill();
        o_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_valid = 1'b1; i_data = 8'(k);
            cyc();
            vectors++;
            if ({o_valid, i_ready, o_afull, o_data} !== {1'b1, (k < 3), (k >= 2), 8'h00}) begin
                miscompares++;
                $display("FAIL fill_%0d: got v/r/af/d=%b/%b/%b/%h want 1/%b/%b/00",
                         k, o_valid, i_ready, o_afull, o_data, (k < 3), (k >= 2));
            end
`ifdef STREAM_FIFO_LEVEL_EN
            vectors++;
            if (o_level !== 3'(k + 1)) begin
                miscompares++;
                $display("FAIL fill_level_%0d: got %0d want %0d", k, o_level, k + 1);
            end
`endif
        end
        i_valid = 1'b0;
    endtask

    task automatic test_full_read();
        i_valid = 1'b1; i_data = 8'h04; o_ready = 1'b1;
        vectors++;
        if (i_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_no_passthru: got i_ready=%b want 0", i_ready);
        end
        cyc();
        o_ready = 1'b0;
        vectors++;
        if ({o_valid, i_ready, o_afull, o_data} !== {1'b1, 1'b1, 1'b1, 8'h01}) begin
            miscompares++;
            $display("FAIL full_read_only: got v/r/af/d=%b/%b/%b/%h want 1/1/1/01",
                     o_valid, i_ready, o_afull, o_data);
        end
        cyc();
        i_valid = 1'b0;
        vectors++;
        if ({o_valid, i_ready, o_afull, o_data} !== {1'b1, 1'b0, 1'b1, 8'h01}) begin
            miscompares++;
            $display("FAIL full_refill: got v/r/af/d=%b/%b/%b/%h want 1/0/1/01",
                     o_valid, i_ready, o_afull, o_data);
        end
        o_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            vectors++;
            if ({o_valid, o_data} !== {1'b1, 8'(k)}) begin
                miscompares++;
                $display("FAIL drain_%0d: got v/d=%b/%h want 1/%h", k, o_valid, o_data, 8'(k));
            end
            cyc();
        end
        o_ready = 1'b0;
        vectors++;
        if ({o_valid, i_ready, o_afull} !== 3'b010) begin
            miscompares++;
            $display("FAIL drain_empty: got v/r/af=%b want 010", {o_valid, i_ready, o_afull});
        end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 10; k++) begin
            i_valid = 1'b1; i_data = 8'(k); o_ready = 1'b1;
            cyc();
            vectors++;
            if ({o_valid, o_afull, o_data} !== {1'b1, 1'b0, 8'(k)}) begin
                miscompares++;
                $display("FAIL stream_%0d: got v/af/d=%b/%b/%h want 1/0/%h", k, o_valid, o_afull, o_data, 8'(k));
            end
`ifdef STREAM_FIFO_LEVEL_EN
            vectors++;
            if (o_level !== 3'd1) begin
                miscompares++;
                $display("FAIL stream_level_%0d: got %0d want 1", k, o_level);
            end
`endif
        end
        i_valid = 1'b0;
        cyc();
        o_ready = 1'b0;
        vectors++;
        if (o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_end: got o_valid=%b want 0", o_valid);
        end
    endtask

    task automatic test_empty_wr_rd();
        i_valid = 1'b1; i_data = 8'hA5; o_ready = 1'b1;
        cyc();
        i_valid = 1'b0; o_ready = 1'b0;
        vectors++;
        if ({o_valid, o_data} !== {1'b1, 8'hA5}) begin
            miscompares++;
            $display("FAIL empty_wr_rd: got v/d=%b/%h want 1/a5", o_valid, o_data);
        end
        o_ready = 1'b1;
        cyc();
        o_ready = 1'b0;
        vectors++;
        if (o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_wr_rd_drain: got o_valid=%b want 0", o_valid);
        end
    endtask

    task automatic test_reset_mid();
        i_valid = 1'b1; i_data = 8'h11;
        cyc();
        i_data = 8'h22;
        cyc();
        i_valid = 1'b0;
        vectors++;
        if ({o_valid, o_data} !== {1'b1, 8'h11}) begin
            miscompares++;
            $display("FAIL mid_pre: got v/d=%b/%h want 1/11", o_valid, o_data);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({o_valid, i_ready, o_afull} !== 3'b000) begin
            miscompares++;
            $display("FAIL mid_async: got v/r/af=%b want 000", {o_valid, i_ready, o_afull});
        end
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        vectors++;
        if ({o_valid, i_ready, o_afull} !== 3'b010) begin
            miscompares++;
            $display("FAIL mid_release: got v/r/af=%b want 010", {o_valid, i_ready, o_afull});
        end
`ifdef STREAM_FIFO_LEVEL_EN
        vectors++;
        if (o_level !== 3'd0) begin
            miscompares++;
            $display("FAIL mid_level: got %0d want 0", o_level);
        end
`endif
        i_valid = 1'b1; i_data = 8'h33;
        cyc();
        i_valid = 1'b0;
        vectors++;
        if ({o_valid, o_data} !== {1'b1, 8'h33}) begin
            miscompares++;
            $display("FAIL mid_new: got v/d=%b/%h want 1/33", o_valid, o_data);
        end
        o_ready = 1'b1;
        cyc();
        o_ready = 1'b0;
        vectors++;
        if (o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_drain: got o_valid=%b want 0", o_valid);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_read();
        test_stream();
        test_empty_wr_rd();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
